cci_mpf_shim_vtp_miss_arb: RTL



---
 rtl/cci_mpf_shim_vtp_miss_arb_pkg.sv | 5 +
 rtl/cci_mpf_shim_vtp_miss_cam_fifo.sv | 73 +++++++
 rtl/cci_mpf_shim_vtp_miss_arb.sv | 81 ++++++++
 3 files changed

// File: rtl/cci_mpf_shim_vtp_miss_arb_pkg.sv
// Shared VTP types used by the miss arbiter and its CAM FIFO.
package cci_mpf_shim_vtp_miss_arb_pkg;
  localparam int CCI_PT_4KB_VA_PAGE_INDEX_BITS = 36;
  typedef logic [CCI_PT_4KB_VA_PAGE_INDEX_BITS-1:0] t_tlb_4kb_va_page_idx;
endpackage

// File: rtl/cci_mpf_shim_vtp_miss_cam_fifo.sv
// Circular miss queue. Two enqueue ports (port 0 first) and a head pop.
// Matching against queued entries is built only with VTP_MISS_ARB_DEDUP_EN.
module cci_mpf_shim_vtp_miss_cam_fifo
  import cci_mpf_shim_vtp_miss_arb_pkg::*;
#(
  parameter int N_MISS_ENTRIES = 4,
  localparam int PW = $clog2(N_MISS_ENTRIES),
  localparam int CW = PW + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             enq_en,
  input  logic [1:0][CCI_PT_4KB_VA_PAGE_INDEX_BITS-1:0] enq_va,
  input  logic                   deq,
  output t_tlb_4kb_va_page_idx   head_va,
  output logic [CW-1:0]          cnt,
  output logic [CW-1:0]          cnt_next,
  output logic                   rdy
);
  t_tlb_4kb_va_page_idx mem [N_MISS_ENTRIES];
  logic [PW-1:0] head, tail;
  logic [1:0]    match, we;
  logic          pair_dup;

  // Same-cycle equal pair always collapses to the port 0 entry.
  assign pair_dup = enq_en[0] && enq_en[1] && (enq_va[0] == enq_va[1]);
  assign we[0]    = rdy && enq_en[0] && !match[0];
  assign we[1]    = rdy && enq_en[1] && !pair_dup && !match[1];
  assign cnt_next = cnt + CW'(we[0]) + CW'(we[1]) - CW'(deq);
  assign head_va  = mem[head];

  always_ff @(posedge clk) begin
    if (we[0]) mem[tail] <= enq_va[0];
    if (we[1]) mem[tail + PW'(we[0])] <= enq_va[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      rdy  <= 1'b1;
    end else begin
      tail <= tail + PW'(we[0]) + PW'(we[1]);
      if (deq) head <= head + PW'(1);
      cnt  <= cnt_next;
      rdy  <= cnt_next <= CW'(N_MISS_ENTRIES - 2);
    end
  end

`ifdef VTP_MISS_ARB_DEDUP_EN
  logic [N_MISS_ENTRIES-1:0] vld;

  // Slots written here are never the head being popped: enqueue needs two free slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld <= '0;
    else begin
      if (we[0]) vld[tail] <= 1'b1;
      if (we[1]) vld[tail + PW'(we[0])] <= 1'b1;
      if (deq)   vld[head] <= 1'b0;
    end
  end

  always_comb begin
    match = '0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N_MISS_ENTRIES; i++)
        if (vld[i] && mem[i] == enq_va[p]) match[p] = 1'b1;
  end
`else
  assign match = '0;
`endif
endmodule

// File: rtl/cci_mpf_shim_vtp_miss_arb.sv
// VTP miss arbiter: queues TLB misses and issues one page walk at a time.
// Optional VTP_MISS_ARB_DEDUP_EN drops misses already queued or in flight.
module cci_mpf_shim_vtp_miss_arb
  import cci_mpf_shim_vtp_miss_arb_pkg::*;
#(
  parameter int N_MISS_ENTRIES = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [1:0]                           missEn,
  input  logic [CCI_PT_4KB_VA_PAGE_INDEX_BITS-1:0] missVA0,
  input  logic [CCI_PT_4KB_VA_PAGE_INDEX_BITS-1:0] missVA1,
  output logic                                 missRdy,
  output logic                                 reqEn,
  output logic [CCI_PT_4KB_VA_PAGE_INDEX_BITS-1:0] reqVA,
  input  logic                                 reqRdy,
  input  logic                                 fillEn,
  input  logic [CCI_PT_4KB_VA_PAGE_INDEX_BITS-1:0] fillVA,
  input  logic                                 notPresent,
  output logic                                 walkErr,
  output logic [CCI_PT_4KB_VA_PAGE_INDEX_BITS-1:0] walkErrVA,
  output logic [$clog2(N_MISS_ENTRIES):0]      missCnt
);
  localparam int CW = $clog2(N_MISS_ENTRIES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} t_state;
  t_state state, state_nxt;

  t_tlb_4kb_va_page_idx head_va;
  logic [CW-1:0]        occ_next;
  logic                 deq;

  cci_mpf_shim_vtp_miss_cam_fifo #(.N_MISS_ENTRIES(N_MISS_ENTRIES)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_en   (missEn),
    .enq_va   ({missVA1, missVA0}),
    .deq      (deq),
    .head_va  (head_va),
    .cnt      (missCnt),
    .cnt_next (occ_next),
    .rdy      (missRdy)
  );

  assign deq = (state == S_WAIT) && ((fillEn && fillVA == head_va) || notPresent);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Look at next-cycle occupancy so a new miss or a retire issues without a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (occ_next != '0) state_nxt = S_REQ;
      S_REQ:   if (reqRdy) state_nxt = S_WAIT;
      S_WAIT:  if (deq) state_nxt = (occ_next != '0) ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reqEn = 1'b0;
    reqVA = '0;
    if (state == S_REQ) begin
      reqEn = 1'b1;
      reqVA = head_va;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      walkErr   <= 1'b0;
      walkErrVA <= '0;
    end else if (state == S_WAIT && notPresent && !walkErr) begin
      walkErr   <= 1'b1;
      walkErrVA <= head_va;
    end
  end
endmodule
